// File: rtl/sram_waitstate_controller.sv
// Avalon-MM slave to asynchronous SRAM bridge with parameterised read/write
// strobe stretching and an idle turnaround window after every access.
module sram_waitstate_controller #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 20,
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2,
  parameter int TURNAROUND = 1
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [ADDR_W-1:0]   avs_address,
  input  logic [DATA_W/8-1:0] avs_byteenable,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [DATA_W-1:0]   avs_writedata,
  output logic                avs_waitrequest,
  output logic [DATA_W-1:0]   avs_readdata,
  output logic                avs_readdatavalid,
  inout  wire  [DATA_W-1:0]   sram_DQ,
  output logic [ADDR_W-1:0]   sram_ADDR,
  output logic [DATA_W/8-1:0] sram_BE_N,
  output logic                sram_CE_N,
  output logic                sram_OE_N,
  output logic                sram_WE_N
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [3:0] RD_CNT   = 4'(READ_WAIT);
  localparam logic [3:0] WR_CNT   = 4'(WRITE_WAIT);
  localparam logic [3:0] TURN_CNT = 4'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

  typedef enum logic [1:0] {IDLE, READ, WRITE, TURN} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic [BE_W-1:0]     be_n_q, be_n_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                dq_oe_q, dq_oe_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                accept;
  logic                cnt_zero;

  assign avs_waitrequest = (state_q != IDLE) | ~reset_reset_n;
  assign accept          = (avs_read | avs_write) & ~avs_waitrequest;
  assign cnt_zero        = (cnt_q == 4'd0);

  // The driver enable flips on the same edge as WE_N, so the bus is never
  // driven outside the write strobe window.
  assign sram_DQ           = dq_oe_q ? wdata_q : 'z;
  assign sram_ADDR         = addr_q;
  assign sram_BE_N         = be_n_q;
  assign sram_CE_N         = ce_n_q;
  assign sram_OE_N         = oe_n_q;
  assign sram_WE_N         = we_n_q;
  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = rvalid_q;

  always_comb begin
    // NOTE: every _d starts from its held value (or its idle level) so no path leaves it unassigned and no latch is inferred.
    state_d  = state_q;
    cnt_d    = cnt_q;
    ce_n_d   = ce_n_q;
    oe_n_d   = oe_n_q;
    we_n_d   = we_n_q;
    be_n_d   = be_n_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    dq_oe_d  = dq_oe_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = avs_address;
          be_n_d  = ~avs_byteenable;
          wdata_d = avs_writedata;
          ce_n_d  = 1'b0;
          // A simultaneous read and write is served as a write only.
          if (avs_write) begin
            state_d = WRITE;
            cnt_d   = WR_CNT;
            we_n_d  = 1'b0;
            dq_oe_d = 1'b1;
          end else begin
            state_d = READ;
            cnt_d   = RD_CNT;
            oe_n_d  = 1'b0;
          end
        end
      end
      READ, WRITE: begin
        if (cnt_zero) begin
          if (state_q == READ) begin
            rdata_d  = sram_DQ;
            rvalid_d = 1'b1;
          end
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          be_n_d  = '1;
          dq_oe_d = 1'b0;
          state_d = (TURNAROUND > 0) ? TURN : IDLE;
          cnt_d   = TURN_CNT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      TURN: begin
        if (cnt_zero) state_d = IDLE;
        else          cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      be_n_q   <= '1;
      addr_q   <= '0;
      wdata_q  <= '0;
      dq_oe_q  <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      be_n_q   <= be_n_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      dq_oe_q  <= dq_oe_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

endmodule

// File: tb/tb_sram_waitstate_controller.sv
// Scoreboard bench: a default 16-bit controller and a 32-bit zero-wait
// controller, each attached to a small behavioural SRAM.
module tb_sram_waitstate_controller;

  localparam int RW = 2;
  localparam int WW = 2;
  localparam logic [15:0] PROBE16 = 16'h6C93;
  localparam logic [31:0] PROBE32 = 32'h6C93_F00D;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rd_exp_t;

  typedef struct {
    logic        is_wr;
    logic [1:0]  be_n;
    logic [15:0] wdata;
    logic [19:0] addr;
  } st_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  rd_exp_t rd_q[$];
  rd_exp_t rd32_q[$];
  st_exp_t st_q[$];

  // ---------------- 16-bit default instance ----------------
  logic [19:0] addr;
  logic [1:0]  be;
  logic        rd, wr;
  logic [15:0] wdata;
  logic        waitreq, rvalid;
  logic [15:0] rdata;
  wire  [15:0] dq;
  logic [19:0] s_addr;
  logic [1:0]  s_be_n;
  logic        ce_n, oe_n, we_n;
  logic [15:0] mem [0:255];

  sram_waitstate_controller dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .avs_address(addr), .avs_byteenable(be), .avs_read(rd), .avs_write(wr),
    .avs_writedata(wdata), .avs_waitrequest(waitreq), .avs_readdata(rdata),
    .avs_readdatavalid(rvalid), .sram_DQ(dq), .sram_ADDR(s_addr),
    .sram_BE_N(s_be_n), .sram_CE_N(ce_n), .sram_OE_N(oe_n), .sram_WE_N(we_n)
  );

  // The bench parks a probe pattern on the bus while the chip is deselected;
  // any stray controller drive corrupts it.
  assign dq = (!ce_n && !oe_n && we_n) ? mem[s_addr[7:0]] : 'z;
  assign dq = ce_n ? PROBE16 : 'z;

  always @(negedge clk)
    if (rst_n && !ce_n && !we_n)
      for (int b = 0; b < 2; b++)
        if (!s_be_n[b]) mem[s_addr[7:0]][b*8 +: 8] <= dq[b*8 +: 8];

  // ---------------- 32-bit zero-wait instance ----------------
  logic [19:0] addr32;
  logic [3:0]  be32;
  logic        rd32, wr32;
  logic [31:0] wdata32;
  logic        waitreq32, rvalid32;
  logic [31:0] rdata32;
  wire  [31:0] dq32;
  logic [19:0] s_addr32;
  logic [3:0]  s_be_n32;
  logic        ce_n32, oe_n32, we_n32;
  logic [31:0] mem32 [0:15];

  sram_waitstate_controller #(
    .DATA_W(32), .ADDR_W(20), .READ_WAIT(0), .WRITE_WAIT(2), .TURNAROUND(0)
  ) dut32 (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .avs_address(addr32), .avs_byteenable(be32), .avs_read(rd32), .avs_write(wr32),
    .avs_writedata(wdata32), .avs_waitrequest(waitreq32), .avs_readdata(rdata32),
    .avs_readdatavalid(rvalid32), .sram_DQ(dq32), .sram_ADDR(s_addr32),
    .sram_BE_N(s_be_n32), .sram_CE_N(ce_n32), .sram_OE_N(oe_n32), .sram_WE_N(we_n32)
  );

  assign dq32 = (!ce_n32 && !oe_n32 && we_n32) ? mem32[s_addr32[3:0]] : 'z;
  assign dq32 = ce_n32 ? PROBE32 : 'z;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitors ----------------
  int run16 = 0;
  always @(negedge clk) begin
    rd_exp_t e;
    st_exp_t s;
    if (!rst_n) begin
      rd_q.delete();
      st_q.delete();
      run16 = 0;
    end else begin
      if (rvalid) begin
        if (rd_q.size() == 0) check("unexpected_rvalid", 1, 0);
        else begin
          e = rd_q.pop_front();
          check("rdata", 64'(rdata), 64'(e.data));
          check("rvalid_cycle", 64'(cyc), 64'(e.due));
        end
      end
      if (!ce_n) begin
        if (st_q.size() == 0) check("unexpected_ce", 1, 0);
        else begin
          s = st_q[0];
          run16++;
          check("oe_n", 64'(oe_n), 64'(s.is_wr));
          check("we_n", 64'(we_n), 64'(!s.is_wr));
          check("be_n", 64'(s_be_n), 64'(s.be_n));
          check("sram_addr", 64'(s_addr), 64'(s.addr));
          if (s.is_wr) check("dq_write", 64'(dq), 64'(s.wdata));
        end
      end else begin
        if (run16 > 0) begin
          s = st_q.pop_front();
          check("strobe_len", 64'(run16), s.is_wr ? 64'(WW + 1) : 64'(RW + 1));
          run16 = 0;
        end
        check("dq_released", 64'(dq), 64'(PROBE16));
      end
    end
  end

  int run32 = 0;
  always @(negedge clk) begin
    rd_exp_t e;
    if (!rst_n) begin
      rd32_q.delete();
      run32 = 0;
    end else begin
      if (rvalid32) begin
        if (rd32_q.size() == 0) check("unexpected_rvalid32", 1, 0);
        else begin
          e = rd32_q.pop_front();
          check("rdata32", 64'(rdata32), 64'(e.data));
          check("rvalid32_cycle", 64'(cyc), 64'(e.due));
        end
      end
      if (!ce_n32) begin
        run32++;
        check("oe_n32", 64'(oe_n32), 0);
        check("we_n32", 64'(we_n32), 1);
        check("be_n32", 64'(s_be_n32), 64'(4'b0000));
      end else begin
        if (run32 > 0) check("strobe_len32", 64'(run32), 1);
        run32 = 0;
        check("dq32_released", 64'(dq32), 64'(PROBE32));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic r, input logic w, input logic [19:0] a,
                       input logic [1:0] b, input logic [15:0] d,
                       input logic [15:0] exp_rd, output int acc);
    bit ok = 1'b0;
    addr = a; be = b; rd = r; wr = w; wdata = d;
    acc = -1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (!waitreq) begin
        ok  = 1'b1;
        acc = cyc;
        st_q.push_back('{is_wr: w, be_n: ~b, wdata: d, addr: a});
        if (!w) rd_q.push_back('{data: 32'(exp_rd), due: cyc + RW + 2});
      end
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic issue32(input logic [19:0] a, input logic [31:0] exp_rd, output int acc);
    bit ok = 1'b0;
    addr32 = a; be32 = 4'hF; rd32 = 1'b1;
    acc = -1;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (!waitreq32) begin
        ok  = 1'b1;
        acc = cyc;
        rd32_q.push_back('{data: exp_rd, due: cyc + 2});
      end
    end
    if (!ok) check("accept32_timeout", 0, 1);
    @(posedge clk); #1;
    rd32 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, t1, t2, t3, rel, a0, a1, a2;
    addr = '0; be = '0; rd = 1'b0; wr = 1'b0; wdata = '0;
    addr32 = '0; be32 = '0; rd32 = 1'b0; wr32 = 1'b0; wdata32 = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);
    for (int i = 0; i < 16; i++) mem32[i] = 32'(i * 7);
    mem[8'h10] = 16'hA5C3;
    mem[8'h20] = 16'hFFFF;
    mem[8'h30] = 16'h5A5A;
    mem[8'h40] = 16'h0F0F;
    mem32[1] = 32'hDEADBEEF;
    mem32[2] = 32'h01234567;
    mem32[3] = 32'hCAFEF00D;

    repeat (2) @(posedge clk);
    #1;
    check("rst_waitreq", 64'(waitreq), 1);
    check("rst_ce_n", 64'(ce_n), 1);
    check("rst_oe_n", 64'(oe_n), 1);
    check("rst_we_n", 64'(we_n), 1);
    check("rst_be_n", 64'(s_be_n), 64'(2'b11));
    check("rst_addr", 64'(s_addr), 0);
    check("rst_rdata", 64'(rdata), 0);
    check("rst_rvalid", 64'(rvalid), 0);
    check("rst_dq", 64'(dq), 64'(PROBE16));
    check("rst_be_n32", 64'(s_be_n32), 64'(4'hF));

    @(posedge clk); #1;
    rst_n = 1'b1;
    rel = cyc;
    issue(1'b1, 1'b0, 20'h00010, 2'b11, 16'h0, 16'hA5C3, t0);
    check("accept_after_reset", 64'(t0), 64'(rel));

    issue(1'b0, 1'b1, 20'h00020, 2'b01, 16'h1234, 16'h0, t1);
    check("rd_to_wr_gap", 64'(t1 - t0), 5);
    issue(1'b1, 1'b0, 20'h00020, 2'b11, 16'h0, 16'hFF34, t2);
    check("wr_to_rd_gap", 64'(t2 - t1), 5);

    issue(1'b0, 1'b1, 20'h00030, 2'b00, 16'h0000, 16'h0, t1);
    issue(1'b1, 1'b0, 20'h00030, 2'b11, 16'h0, 16'h5A5A, t2);
    issue(1'b1, 1'b0, 20'h00010, 2'b01, 16'h0, 16'hA5C3, t2);

    issue(1'b1, 1'b1, 20'h00040, 2'b11, 16'hBEEF, 16'h0, t1);
    issue(1'b1, 1'b0, 20'h00040, 2'b11, 16'h0, 16'hBEEF, t2);

    issue(1'b1, 1'b0, 20'h00010, 2'b11, 16'h0, 16'hA5C3, t3);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_ce_n", 64'(ce_n), 1);
    check("abort_oe_n", 64'(oe_n), 1);
    check("abort_waitreq", 64'(waitreq), 1);
    check("abort_rvalid", 64'(rvalid), 0);
    check("abort_addr", 64'(s_addr), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rel = cyc;
    issue(1'b1, 1'b0, 20'h00030, 2'b11, 16'h0, 16'h5A5A, t0);
    check("accept_after_abort", 64'(t0), 64'(rel));

    issue32(20'h00001, 32'hDEADBEEF, a0);
    issue32(20'h00002, 32'h01234567, a1);
    issue32(20'h00003, 32'hCAFEF00D, a2);
    check("b2b32_gap_a", 64'(a1 - a0), 2);
    check("b2b32_gap_b", 64'(a2 - a1), 2);

    repeat (12) @(posedge clk);
    #1;
    check("rd_q_drained", 64'(rd_q.size()), 0);
    check("st_q_drained", 64'(st_q.size()), 0);
    check("rd32_q_drained", 64'(rd32_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
